// File: rtl/mem_port_arbiter_if.sv
// Bus bundle joining the fetch and load/store requesters, the port arbiter
// and the unified instruction/data memory.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_valid;
  logic [DATA_W-1:0] if_rdata;

  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_gnt;
  logic              d_valid;
  logic [DATA_W-1:0] d_rdata;

  logic [ADDR_W-1:0] mem_a;
  logic [DATA_W-1:0] mem_wd;
  logic              mem_we;
  logic              mem_adr_src;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  if_req, if_addr,
    output if_gnt, if_valid, if_rdata,
    input  d_req, d_we, d_addr, d_wdata,
    output d_gnt, d_valid, d_rdata,
    output mem_a, mem_wd, mem_we, mem_adr_src,
    input  mem_rdata
  );

  modport master (
    output if_req, if_addr,
    input  if_gnt, if_valid, if_rdata,
    output d_req, d_we, d_addr, d_wdata,
    input  d_gnt, d_valid, d_rdata,
    input  mem_a, mem_wd, mem_we, mem_adr_src,
    output mem_rdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares the single memory port of the multicycle CPU between instruction fetch
// and load/store, sequencing the memory controls and returning registered read data.
module mem_port_arbiter #(
  parameter int ADDR_W        = 32,
  parameter int DATA_W        = 32,
  parameter bit DATA_PRIORITY = 1'b1,
  parameter int CNT_W         = 16
) (
  input  logic             clk,
  input  logic             rst,
  mem_port_arbiter_if.slave bus,
  output logic             busy,
  output logic [CNT_W-1:0] fetch_cnt,
  output logic [CNT_W-1:0] data_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DATA  = 2'd2,
    ST_DWAIT = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t              state_r;
  state_t              state_nxt_s;
  logic [ADDR_W-1:0]   addr_r;
  logic [DATA_W-1:0]   wdata_r;
  logic                we_r;
  logic                last_data_r;
  logic [CNT_W-1:0]    fetch_cnt_r;
  logic [CNT_W-1:0]    data_cnt_r;
  logic                if_valid_r;
  logic                d_valid_r;
  logic [DATA_W-1:0]   if_rdata_r;
  logic [DATA_W-1:0]   d_rdata_r;

  logic                if_gnt_s;
  logic                d_gnt_s;
  logic [ADDR_W-1:0]   mem_a_s;
  logic                mem_we_s;
  logic                mem_src_s;

  // Arbitration, next state and memory-port decode from state and latched fields
  always_comb begin
    state_nxt_s = state_r;
    if_gnt_s    = 1'b0;
    d_gnt_s     = 1'b0;
    mem_a_s     = {ADDR_W{1'b0}};
    mem_we_s    = 1'b0;
    mem_src_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        // Round-robin: on contention the requester not served last time wins.
        if (bus.d_req && ((DATA_PRIORITY != 1'b0) || !bus.if_req || !last_data_r)) begin
          d_gnt_s     = 1'b1;
          state_nxt_s = ST_DATA;
        end else if (bus.if_req) begin
          if_gnt_s    = 1'b1;
          state_nxt_s = ST_FETCH;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_FETCH: begin
        mem_a_s     = addr_r;
        state_nxt_s = ST_IDLE;
      end
      ST_DATA: begin
        mem_a_s     = addr_r;
        mem_src_s   = 1'b1;
        mem_we_s    = we_r;
        state_nxt_s = ST_DWAIT;
      end
      ST_DWAIT: begin
        mem_a_s     = addr_r;
        mem_src_s   = 1'b1;
        state_nxt_s = ST_IDLE;
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State register, latched winner request, grant history and grant counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      addr_r      <= {ADDR_W{1'b0}};
      wdata_r     <= {DATA_W{1'b0}};
      we_r        <= 1'b0;
      last_data_r <= 1'b1;
      fetch_cnt_r <= {CNT_W{1'b0}};
      data_cnt_r  <= {CNT_W{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      if (d_gnt_s) begin
        addr_r      <= bus.d_addr;
        wdata_r     <= bus.d_wdata;
        we_r        <= bus.d_we;
        last_data_r <= 1'b1;
        data_cnt_r  <= data_cnt_r + CNT_ONE;
      end else if (if_gnt_s) begin
        addr_r      <= bus.if_addr;
        wdata_r     <= {DATA_W{1'b0}};
        we_r        <= 1'b0;
        last_data_r <= 1'b0;
        fetch_cnt_r <= fetch_cnt_r + CNT_ONE;
      end
    end
  end

  // Return path: capture memory read data and pulse the matching valid
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      if_valid_r <= 1'b0;
      d_valid_r  <= 1'b0;
      if_rdata_r <= {DATA_W{1'b0}};
      d_rdata_r  <= {DATA_W{1'b0}};
    end else begin
      if_valid_r <= 1'b0;
      d_valid_r  <= 1'b0;
      if (state_r == ST_FETCH) begin
        if_rdata_r <= bus.mem_rdata;
        if_valid_r <= 1'b1;
      end
      if (state_r == ST_DWAIT) begin
        d_rdata_r <= bus.mem_rdata;
        d_valid_r <= 1'b1;
      end
    end
  end

  assign bus.if_gnt      = if_gnt_s;
  assign bus.d_gnt       = d_gnt_s;
  assign bus.if_valid    = if_valid_r;
  assign bus.d_valid     = d_valid_r;
  assign bus.if_rdata    = if_rdata_r;
  assign bus.d_rdata     = d_rdata_r;
  assign bus.mem_a       = mem_a_s;
  assign bus.mem_wd      = wdata_r;
  assign bus.mem_we      = mem_we_s;
  assign bus.mem_adr_src = mem_src_s;
  assign busy            = (state_r != ST_IDLE);
  assign fetch_cnt       = fetch_cnt_r;
  assign data_cnt        = data_cnt_r;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomised bench: a data-priority arbiter and a round-robin arbiter (4-bit counters)
// run side by side, each against a transaction-level model of grants and latencies.
module tb_mem_port_arbiter;

  localparam int NCYC = 800;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wd;
  } dop_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int tests  = 0;
  int errors = 0;

  task automatic check_val(input string tag, input int inst, input logic [31:0] obs,
                           input logic [31:0] exp);
    tests = tests + 1;
    if (obs !== exp) begin
      errors = errors + 1;
      $display("FAIL %s inst%0d got %h expected %h", tag, inst, obs, exp);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_inst
    localparam bit DP = (g == 0);
    localparam int CW = (g == 0) ? 16 : 4;

    logic          rst;
    logic          busy;
    logic [CW-1:0] fcnt_o;
    logic [CW-1:0] dcnt_o;
    bit            fin = 1'b0;

    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .DATA_PRIORITY(DP), .CNT_W(CW)) dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus),
      .busy      (busy),
      .fetch_cnt (fcnt_o),
      .data_cnt  (dcnt_o)
    );

    // Unified memory: combinational instruction read, clocked data write/read register
    logic [31:0] imem  [16];
    logic [31:0] dseed [16];
    logic [31:0] dmem  [16];
    logic [31:0] rd_q;

    assign bus.mem_rdata = bus.mem_adr_src ? rd_q : imem[bus.mem_a[5:2]];

    always @(posedge clk) begin
      if (rst) begin
        for (int i = 0; i < 16; i++) dmem[i] <= dseed[i];
      end else if (bus.mem_adr_src) begin
        if (bus.mem_we) begin
          dmem[bus.mem_a[3:0]] <= bus.mem_wd;
          rd_q <= bus.mem_wd;
        end else begin
          rd_q <= dmem[bus.mem_a[3:0]];
        end
      end
    end

    logic [31:0] ref_dmem [16];
    logic [31:0] fq [$];
    dop_t        dq [$];
    dop_t        dop;
    logic [31:0] if_addr_v;
    bit          if_act, d_act;

    initial begin
      int t, idle_at, acc_g, fv_at, dv_at, fcnt, dcnt, mode;
      bit acc_data, acc_we, dv_we, last_data, idle, e_ig, e_dg, e_ifv, e_dv, e_we, e_src;
      bit abort_armed, abort_done;
      logic [31:0] acc_addr, acc_wd, fv_val, dv_val, dv_addr, exp_ifr, exp_dr, e_a;

      for (int i = 0; i < 16; i++) begin
        imem[i]  = $urandom;
        dseed[i] = $urandom;
      end
      imem[2] = 32'h0050_0093;
      rst = 1'b1;
      if_act = 1'b0; d_act = 1'b0; if_addr_v = 32'd0; dop = '0;
      bus.if_req = 1'b0; bus.if_addr = 32'd0;
      bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = 32'd0; bus.d_wdata = 32'd0;
      abort_armed = 1'b0; abort_done = 1'b0;

      repeat (2) @(posedge clk);
      @(negedge clk);
      check_val("rst_if_valid", g, 32'(bus.if_valid), 32'd0);
      check_val("rst_d_valid", g, 32'(bus.d_valid), 32'd0);
      check_val("rst_if_rdata", g, bus.if_rdata, 32'd0);
      check_val("rst_d_rdata", g, bus.d_rdata, 32'd0);
      check_val("rst_busy", g, 32'(busy), 32'd0);
      check_val("rst_mem_we", g, 32'(bus.mem_we), 32'd0);
      check_val("rst_fcnt", g, 32'(fcnt_o), 32'd0);
      check_val("rst_dcnt", g, 32'(dcnt_o), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;

      t = 0; idle_at = 0; acc_g = -10; fv_at = -1; dv_at = -1; fcnt = 0; dcnt = 0;
      acc_data = 1'b0; acc_we = 1'b0; acc_addr = 32'd0; acc_wd = 32'd0;
      fv_val = 32'd0; dv_val = 32'd0; dv_addr = 32'd0; dv_we = 1'b0;
      last_data = 1'b1; exp_ifr = 32'd0; exp_dr = 32'd0;
      for (int i = 0; i < 16; i++) ref_dmem[i] = dseed[i];

      for (int c = 0; c < NCYC; c++) begin
        // 0: directed fetch, 1: directed store/load, 2: both held, 4: store to abort, 3: random
        if (c < 6) mode = 0;
        else if (c < 20) mode = 1;
        else if (c < 60) mode = 2;
        else if (c < 80) mode = 4;
        else mode = 3;
        if (c == 0) fq.push_back(32'h0000_0008);
        if (c == 6) begin
          dq.push_back({1'b1, 32'd5, 32'hDEAD_BEEF});
          dq.push_back({1'b0, 32'd5, 32'h0000_0000});
        end
        if (c == 60) begin
          dq.push_back({1'b1, 32'($urandom_range(0, 15)), $urandom});
          abort_armed = 1'b1;
        end

        if (!if_act) begin
          if (fq.size() != 0) begin
            if_act = 1'b1; if_addr_v = fq.pop_front();
          end else if (mode == 2 || (mode == 3 && $urandom_range(0, 2) != 0)) begin
            if_act = 1'b1; if_addr_v = 32'($urandom_range(0, 15)) << 2;
          end
        end else if (mode == 3 && $urandom_range(0, 15) == 0) begin
          if_act = 1'b0;
        end
        if (!d_act) begin
          if (dq.size() != 0) begin
            d_act = 1'b1; dop = dq.pop_front();
          end else if (mode == 2 || (mode == 3 && $urandom_range(0, 2) == 0)) begin
            d_act = 1'b1;
            dop.we = 1'($urandom_range(0, 1));
            dop.addr = 32'($urandom_range(0, 15));
            dop.wd = $urandom;
          end
        end else if (mode == 3 && $urandom_range(0, 15) == 0) begin
          d_act = 1'b0;
        end
        bus.if_req = if_act; bus.if_addr = if_addr_v;
        bus.d_req = d_act; bus.d_we = dop.we; bus.d_addr = dop.addr; bus.d_wdata = dop.wd;

        @(negedge clk);
        e_ifv = (t == fv_at);
        if (e_ifv) exp_ifr = fv_val;
        e_dv = (t == dv_at);
        if (e_dv) begin
          exp_dr = dv_val;
          if (dv_we) ref_dmem[dv_addr[3:0]] = dv_val;
        end
        idle = (t >= idle_at);
        e_ig = 1'b0; e_dg = 1'b0;
        if (idle) begin
          if (if_act && d_act) begin
            if (DP) e_dg = 1'b1;
            else if (last_data) e_ig = 1'b1;
            else e_dg = 1'b1;
          end else begin
            e_ig = if_act;
            e_dg = d_act;
          end
        end
        e_a = 32'd0; e_src = 1'b0; e_we = 1'b0;
        if (!idle) begin
          e_a = acc_addr;
          e_src = acc_data;
          e_we = acc_data && acc_we && (t == acc_g + 1);
        end

        check_val("if_gnt", g, 32'(bus.if_gnt), 32'(e_ig));
        check_val("d_gnt", g, 32'(bus.d_gnt), 32'(e_dg));
        check_val("if_valid", g, 32'(bus.if_valid), 32'(e_ifv));
        check_val("d_valid", g, 32'(bus.d_valid), 32'(e_dv));
        check_val("if_rdata", g, bus.if_rdata, exp_ifr);
        check_val("d_rdata", g, bus.d_rdata, exp_dr);
        check_val("busy", g, 32'(busy), 32'(!idle));
        check_val("mem_a", g, bus.mem_a, e_a);
        check_val("mem_adr_src", g, 32'(bus.mem_adr_src), 32'(e_src));
        check_val("mem_we", g, 32'(bus.mem_we), 32'(e_we));
        check_val("fetch_cnt", g, 32'(fcnt_o), 32'(fcnt % (1 << CW)));
        check_val("data_cnt", g, 32'(dcnt_o), 32'(dcnt % (1 << CW)));
        if (e_we) check_val("mem_wd", g, bus.mem_wd, acc_wd);
        if (c == 2) begin
          check_val("t1_if_rdata", g, bus.if_rdata, 32'h0050_0093);
          check_val("t1_fetch_cnt", g, 32'(fcnt_o), 32'd1);
        end
        if (c == 12) begin
          check_val("t2_load_valid", g, 32'(bus.d_valid), 32'd1);
          check_val("t2_load_data", g, bus.d_rdata, 32'hDEAD_BEEF);
        end

        if (e_ig) begin
          acc_g = t; acc_data = 1'b0; acc_we = 1'b0; acc_addr = if_addr_v;
          idle_at = t + 2; fv_at = t + 2; fv_val = imem[if_addr_v[5:2]];
          fcnt = fcnt + 1; last_data = 1'b0; if_act = 1'b0;
        end
        if (e_dg) begin
          acc_g = t; acc_data = 1'b1; acc_we = dop.we; acc_addr = dop.addr; acc_wd = dop.wd;
          idle_at = t + 3; dv_at = t + 3; dv_we = dop.we; dv_addr = dop.addr;
          dv_val = dop.we ? dop.wd : ref_dmem[dop.addr[3:0]];
          dcnt = dcnt + 1; last_data = 1'b1; d_act = 1'b0;
        end

        // Reset while a store is driving the memory: everything must return to idle at once
        if (abort_armed && !idle && acc_data && acc_we && (t == acc_g + 1)) begin
          rst = 1'b1;
          if_act = 1'b0; d_act = 1'b0; fq.delete(); dq.delete();
          bus.if_req = 1'b0; bus.d_req = 1'b0;
          #1;
          check_val("abort_mem_we", g, 32'(bus.mem_we), 32'd0);
          check_val("abort_busy", g, 32'(busy), 32'd0);
          check_val("abort_d_valid", g, 32'(bus.d_valid), 32'd0);
          check_val("abort_fcnt", g, 32'(fcnt_o), 32'd0);
          check_val("abort_dcnt", g, 32'(dcnt_o), 32'd0);
          check_val("abort_if_rdata", g, bus.if_rdata, 32'd0);
          check_val("abort_d_rdata", g, bus.d_rdata, 32'd0);
          idle_at = t + 1; fv_at = -1; dv_at = -1; last_data = 1'b1;
          fcnt = 0; dcnt = 0; exp_ifr = 32'd0; exp_dr = 32'd0;
          for (int i = 0; i < 16; i++) ref_dmem[i] = dseed[i];
          abort_armed = 1'b0; abort_done = 1'b1;
        end
        t = t + 1;
        @(posedge clk); #1;
        rst = 1'b0;
      end
      check_val("abort_seen", g, 32'(abort_done), 32'd1);
      fin = 1'b1;
    end
  end

  initial begin
    for (int i = 0; i < 5000 && !(g_inst[0].fin && g_inst[1].fin); i++) @(posedge clk);
    check_val("completion", -1, 32'(g_inst[0].fin && g_inst[1].fin), 32'd1);
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
